fp_divider: RTL
===============

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have parameter: QNAN, 32'h7FC00000, canonical quiet NaN returned for invalid operations.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the single clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: A  input  32  IEEE-754 single dividend; sampled at the accepting edge.
REQ-006 SHALL have port: B  input  32  IEEE-754 single divisor; sampled at the accepting edge.
REQ-007 SHALL have port: quotient  output  32  A/B result; registered; held until the next completion.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: busy  output  1  high from the accepting edge until the edge that asserts done.

Function
REQ-010 SHALL implement states IDLE, DIV and NORM; reset state is IDLE.
REQ-011 IDLE with start=1 at edge N SHALL latch A and B, initialise the remainder to {2'b0,1,A[22:0]} and the iteration count to 24, and go to DIV.
REQ-012 IDLE with start=0 SHALL stay in IDLE with done=0.
REQ-013 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-014 DIV SHALL run one restoring step per cycle over exactly 25 cycles (edges N+1..N+25), producing quotient bit q[i] for i = 24..0.
REQ-015 Each DIV step: if R >= Mb = {1,B[22:0]} then q[i]=1 and R=(R-Mb)<<1; otherwise q[i]=0 and R=R<<1.
REQ-016 The remainder register SHALL be 26 bits wide.
REQ-017 After the i=0 step, DIV SHALL go to NORM.
REQ-018 NORM at edge N+26 SHALL write quotient, set done=1, clear busy, and return to IDLE.
REQ-019 Total latency SHALL be 26 edges after the accepting edge, constant for all operands, special cases included.
REQ-020 done SHALL fall at the next edge, so it is high for exactly one cycle.
REQ-021 A new start SHALL be accepted at the edge immediately after the done cycle, and not in the same cycle as done.
REQ-022 Sign SHALL be A[31]^B[31] for all results except NaN.
REQ-023 Normalisation when q[24]=1: mantissa = q[23:1] and e = Ea-Eb+127.
REQ-024 Normalisation when q[24]=0: mantissa = q[22:0] and e = Ea-Eb+126.
REQ-025 e SHALL be computed as a signed 10-bit value.
REQ-026 The mantissa SHALL be truncated, with no rounding.
REQ-027 e >= 255 SHALL give signed infinity (exponent 8'hFF, mantissa 0).
REQ-028 e <= 0 SHALL give signed zero; no subnormal outputs.
REQ-029 Subnormal inputs (exponent 0) SHALL be treated as zero.
REQ-030 Special-case priority: 1) either operand NaN, 0/0, or inf/inf gives QNAN; 2) A inf or B zero gives signed infinity; 3) A zero or B inf gives signed zero; 4) otherwise the normal path.
REQ-031 Special-case decode SHALL use the latched operands, so changes on A and B after acceptance have no effect.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, quotient=0, done=0, busy=0, and clear the remainder and counter, independent of clk.
REQ-033 rst asserted mid-operation SHALL abort the operation with no done pulse.
REQ-034 The first start after rst deasserts SHALL be accepted normally.
REQ-035 Registers other than the remainder and counter need no reset, but outputs SHALL never show X after reset.

Verification
REQ-036 A=0x40C00000 (6.0), B=0x40000000 (2.0), start at edge N -> quotient=0x40400000, done=1 only in the cycle after edge N+26, busy high over edges N..N+25.
REQ-037 A=0x3F800000, B=0x40400000 -> quotient=0x3EAAAAAA (truncated 1/3); A=0xBF800000, B=0x3F000000 -> quotient=0xC0000000.
REQ-038 A=0x3F800000, B=0x00000000 -> 0x7F800000; A=0, B=0 -> 0x7FC00000; A=0x7F800000, B=0x7F800000 -> 0x7FC00000; all after 26 edges.
REQ-039 A=0x7F000000, B=0x00800000 -> 0x7F800000 (overflow); A=0x00800000, B=0x7F000000 -> 0x00000000 (underflow).
REQ-040 rst pulsed 10 edges after acceptance -> done never rises, quotient=0, busy=0; a start 2 cycles after release with 6.0/2.0 -> 0x40400000 after 26 edges.
REQ-041 start held high continuously with operands changed every cycle -> each result matches the operands latched at its accepting edge; acceptances are 27 edges apart.

Source files
------------

// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle for fp_divider.
// master drives start/A/B and observes quotient/done/busy; slave is the divider side.
// start is honoured only while busy is low; quotient is valid from the done pulse onward.
interface fp_divider_if;
  logic        start;     // request, sampled only when the divider is idle
  logic [31:0] A;         // IEEE-754 single dividend
  logic [31:0] B;         // IEEE-754 single divisor
  logic [31:0] quotient;  // registered result, held until the next completion
  logic        done;      // one-cycle completion pulse
  logic        busy;      // high from the accepting edge until the done edge

  modport master (output start, A, B, input quotient, done, busy);
  modport slave  (input start, A, B, output quotient, done, busy);
endinterface

// File: rtl/fp_divider.sv
// Single-precision divider: restoring mantissa division, truncated result, no subnormals.
// Latency: 26 edges from the accepting edge to the edge that raises done, for all operands.
// Backpressure: start is ignored while busy (including the done cycle); no input queueing.
// Ports: clk, rst (async active-high); bus (slave modport): start, A, B -> quotient, done, busy.
module fp_divider #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input logic         clk,
  input logic         rst,
  fp_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] quot_q, quot_d;
  logic [25:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] q_q, q_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Divisor mantissa with hidden bit, aligned to the 26-bit remainder.
  logic [25:0] mb;
  logic [25:0] diff;
  assign mb   = {2'b01, b_q[22:0]};
  assign diff = rem_q - mb;

  // Operand classification on the latched operands; exponent 0 counts as zero.
  logic [7:0] ea, eb;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign a_nan  = (&ea) && (|a_q[22:0]);
  assign b_nan  = (&eb) && (|b_q[22:0]);
  assign a_inf  = (&ea) && !(|a_q[22:0]);
  assign b_inf  = (&eb) && !(|b_q[22:0]);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign sign   = a_q[31] ^ b_q[31];

  logic signed [9:0] e_norm;
  logic [22:0]       mant;
  logic [31:0]       result;

  always_comb begin
    // Quotient of two normalised mantissas lies in (0.5, 2): q[24] picks the exponent bias.
    e_norm = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (q_q[24] ? 10'sd127 : 10'sd126);
    mant   = q_q[24] ? q_q[23:1] : q_q[22:0];
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      result = QNAN;
    else if (a_inf || b_zero)
      result = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      result = {sign, 31'd0};
    else if (e_norm >= 10'sd255)
      result = {sign, 8'hFF, 23'd0};
    else if (e_norm <= 10'sd0)
      result = {sign, 31'd0};
    else
      result = {sign, e_norm[7:0], mant};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          rem_d   = {2'b00, 1'b1, bus.A[22:0]};
          cnt_d   = 5'd24;
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        // One restoring step; cnt_q is the index of the bit being produced.
        if (rem_q >= mb) begin
          q_d   = {q_q[23:0], 1'b1};
          rem_d = diff << 1;
        end else begin
          q_d   = {q_q[23:0], 1'b0};
          rem_d = rem_q << 1;
        end
        if (cnt_q == 5'd0)
          state_d = NORM;
        else
          cnt_d = cnt_q - 5'd1;
      end
      NORM: begin
        quot_d  = result;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quot_q  <= 32'd0;
      rem_q   <= 26'd0;
      cnt_q   <= 5'd0;
      q_q     <= 25'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.quotient = quot_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule
